// File: rtl/bldc_commutation_ctrl.sv
// Six-step hall commutation sequencer with dead time, fault latching and commutation count.
// Optional stall timer: define BLDC_STALL_DETECT_EN.
module bldc_commutation_ctrl #(
  parameter int DEAD_CYCLES  = 1024,
  parameter int DEAD_W       = 11,
  parameter int COUNT_W      = 16,
  parameter int STALL_CYCLES = 1_600_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               dir,
  input  logic [2:0]         hall,
  input  logic               fault_n,
  input  logic               clear_fault,
  output logic               gha,
  output logic               gla,
  output logic               ghb,
  output logic               glb,
  output logic               ghc,
  output logic               glc,
  output logic [2:0]         state,
  output logic [2:0]         sector,
  output logic               fault,
  output logic [1:0]         fault_cause,
  output logic [COUNT_W-1:0] comm_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DEAD  = 3'd1,
    S_DRIVE = 3'd2,
    S_FAULT = 3'd3,
    S_STALL = 3'd4
  } st_t;

  st_t               st;
  logic [2:0]        hall_m, hall_s;
  logic              flt_m, flt_s;
  logic [2:0]        sec_prev;
  logic              dir_prev;
  logic [DEAD_W-1:0] cnt;
  logic [5:0]        gates;
  logic [1:0]        cause;
  logic [COUNT_W-1:0] cc;
  logic              changed;
  logic              valid_step;
  logic              hall_err;

`ifdef BLDC_STALL_DETECT_EN
  localparam int TW = $clog2(STALL_CYCLES + 1);
  logic [TW-1:0] tmr;
`else
  logic unused_stall;
  assign unused_stall = (STALL_CYCLES != 0);
`endif

  // Fault is synchronized inverted so the cleared sync regs mean "no fault".
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hall_m <= 3'b000;
      hall_s <= 3'b000;
      flt_m  <= 1'b0;
      flt_s  <= 1'b0;
    end else begin
      hall_m <= hall;
      hall_s <= hall_m;
      flt_m  <= ~fault_n;
      flt_s  <= flt_m;
    end
  end

  always_comb begin
    sector = 3'd7;
    unique case (hall_s)
      3'b101:  sector = 3'd0;
      3'b100:  sector = 3'd1;
      3'b110:  sector = 3'd2;
      3'b010:  sector = 3'd3;
      3'b011:  sector = 3'd4;
      3'b001:  sector = 3'd5;
      default: sector = 3'd7;
    endcase
  end

  // Pattern bits: {gha,gla,ghb,glb,ghc,glc}
  function automatic logic [5:0] pattern(input logic [2:0] s, input logic d);
    logic [5:0] p;
    p = 6'b000000;
    if (d) begin
      unique case (s)
        3'd0:    p = 6'b000110;
        3'd1:    p = 6'b100100;
        3'd2:    p = 6'b100001;
        3'd3:    p = 6'b001001;
        3'd4:    p = 6'b011000;
        3'd5:    p = 6'b010010;
        default: p = 6'b000000;
      endcase
    end else begin
      unique case (s)
        3'd0:    p = 6'b001001;
        3'd1:    p = 6'b011000;
        3'd2:    p = 6'b010010;
        3'd3:    p = 6'b000110;
        3'd4:    p = 6'b100100;
        3'd5:    p = 6'b100001;
        default: p = 6'b000000;
      endcase
    end
    return p;
  endfunction

  assign changed    = (sector != sec_prev) || (dir != dir_prev);
  assign valid_step = (sector != 3'd7) && (sec_prev != 3'd7) &&
                      (sector != sec_prev);
  assign hall_err   = (sector == 3'd7) &&
                      (st == S_DEAD || st == S_DRIVE || st == S_STALL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= S_IDLE;
      gates    <= 6'b000000;
      cnt      <= '0;
      cause    <= 2'b00;
      cc       <= '0;
      sec_prev <= 3'd7;
      dir_prev <= 1'b0;
`ifdef BLDC_STALL_DETECT_EN
      tmr      <= '0;
`endif
    end else begin
      sec_prev <= sector;
      dir_prev <= dir;
      gates    <= 6'b000000;
      if (valid_step && (st == S_DEAD || st == S_DRIVE))
        cc <= cc + 1'b1;
      if (flt_s || hall_err) begin
        st    <= S_FAULT;
        cause <= cause | {hall_err, flt_s};
      end else begin
        unique case (st)
          S_IDLE: begin
            if (enable && sector != 3'd7) begin
              st  <= S_DEAD;
              cnt <= DEAD_W'(DEAD_CYCLES);
            end
          end
          S_DEAD: begin
            if (!enable) begin
              st <= S_IDLE;
            end else if (changed) begin
              cnt <= DEAD_W'(DEAD_CYCLES);
            end else if (cnt == '0) begin
              st    <= S_DRIVE;
              gates <= pattern(sector, dir);
`ifdef BLDC_STALL_DETECT_EN
              tmr   <= '0;
`endif
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_DRIVE: begin
            if (!enable) begin
              st <= S_IDLE;
            end else if (changed) begin
              st  <= S_DEAD;
              cnt <= DEAD_W'(DEAD_CYCLES);
            end else begin
`ifdef BLDC_STALL_DETECT_EN
              if (tmr == TW'(STALL_CYCLES - 1)) begin
                st <= S_STALL;
              end else begin
                tmr   <= tmr + 1'b1;
                gates <= pattern(sector, dir);
              end
`else
              gates <= pattern(sector, dir);
`endif
            end
          end
          S_FAULT: begin
            if (clear_fault && sector != 3'd7) begin
              st    <= S_IDLE;
              cause <= 2'b00;
            end
          end
          S_STALL: begin
            if (clear_fault || !enable)
              st <= S_IDLE;
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

  assign {gha, gla, ghb, glb, ghc, glc} = gates;
  assign state       = st;
  assign fault       = (st == S_FAULT) || (st == S_STALL);
  assign fault_cause = cause;
  assign comm_count  = cc;

endmodule

// File: tb/tb_bldc_commutation_ctrl.sv
// Scoreboard bench for bldc_commutation_ctrl: expected gate patterns queued
// on each hall/dir step and compared when the new pattern appears.
module tb_bldc_commutation_ctrl;

  localparam int D  = 1024;
  localparam int CW = 4;
`ifdef BLDC_STALL_DETECT_EN
  localparam int HOLD = 0;
`else
  localparam int HOLD = 5000;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          dir = 1'b1;
  logic [2:0]    hall = 3'b000;
  logic          fault_n = 1'b1;
  logic          clear_fault = 1'b0;
  logic          gha, gla, ghb, glb, ghc, glc;
  logic [2:0]    state, sector;
  logic          fault;
  logic [1:0]    fault_cause;
  logic [CW-1:0] comm_count;
  logic [5:0]    gv;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_exp  = 0;
  logic [5:0] exp_q[$];

  bldc_commutation_ctrl #(
    .DEAD_CYCLES(D), .DEAD_W(11), .COUNT_W(CW), .STALL_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .hall(hall),
    .fault_n(fault_n), .clear_fault(clear_fault),
    .gha(gha), .gla(gla), .ghb(ghb), .glb(glb), .ghc(ghc), .glc(glc),
    .state(state), .sector(sector), .fault(fault),
    .fault_cause(fault_cause), .comm_count(comm_count)
  );

  always #5 clk = ~clk;
  assign gv = {gha, gla, ghb, glb, ghc, glc};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int hsec(input logic [2:0] h);
    case (h)
      3'b101:  return 0;
      3'b100:  return 1;
      3'b110:  return 2;
      3'b010:  return 3;
      3'b011:  return 4;
      3'b001:  return 5;
      default: return 7;
    endcase
  endfunction

  // Phase index 0=A 1=B 2=C; reverse swaps the forward high/low phases.
  function automatic logic [5:0] model(input logic [2:0] h, input logic d);
    int fh[6];
    int fl[6];
    int s, hi, lo;
    logic [5:0] g;
    fh = '{2, 0, 0, 1, 1, 2};
    fl = '{1, 1, 2, 2, 0, 0};
    g = '0;
    s = hsec(h);
    if (s == 7) return g;
    hi = d ? fh[s] : fl[s];
    lo = d ? fl[s] : fh[s];
    g[5-2*hi] = 1'b1;
    g[4-2*lo] = 1'b1;
    return g;
  endfunction

  task automatic meas(output int off);
    int k;
    off = 0;
    k = 0;
    while (gv != 6'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    while (gv == 6'b0 && off < 3000) begin
      off++;
      @(negedge clk);
    end
  endtask

  task automatic wait_on();
    int k;
    k = 0;
    while (gv == 6'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_state(input logic [2:0] s);
    int k;
    k = 0;
    while (state != s && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [5:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(gv), 32'(e));
    end
  endtask

  task automatic step(input logic [2:0] h, input logic d, input string tag);
    int off;
    if (hsec(h) != 7 && hsec(hall) != 7 && h != hall) cnt_exp++;
    hall = h;
    dir = d;
    exp_q.push_back(model(h, d));
    meas(off);
    chk({tag, "_off"}, 32'(off), 32'(D + 1));
    pop_chk(tag);
    if (HOLD > off + 3) repeat (HOLD - off - 3) @(negedge clk);
  endtask

  task automatic clear_pulse();
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
  endtask

  initial begin
    int off;
    logic [2:0] seq[6];
    logic [2:0] wrap[10];
    seq  = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    wrap = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b101,
             3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    repeat (3) @(negedge clk);
    chk("rst_gates", 32'(gv), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_sector", 32'(sector), 32'd7);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cause", 32'(fault_cause), 32'd0);
    chk("rst_count", 32'(comm_count), 32'd0);

    // Start-up: sync latency + IDLE cycle + full dead time
    reset = 1'b0;
    enable = 1'b1;
    dir = 1'b1;
    hall = seq[0];
    exp_q.push_back(model(seq[0], 1'b1));
    off = 0;
    while (off < 3000) begin
      @(negedge clk);
      if (gv != 6'b0) break;
      off++;
    end
    chk("start_off", 32'(off), 32'(D + 3));
    pop_chk("start_pat");
    chk("start_sector", 32'(sector), 32'd0);
    chk("start_state", 32'(state), 32'd2);
    if (HOLD > off) repeat (HOLD - off) @(negedge clk);

    for (int i = 1; i < 6; i++) step(seq[i], 1'b1, "fwd");
    chk("fwd_count", 32'(comm_count), 32'(cnt_exp % (1 << CW)));
    chk("fwd_count5", 32'(cnt_exp), 32'd5);

    // Direction reversal at sector B
    step(3'b100, 1'b1, "fwd_b");
    step(3'b100, 1'b0, "rev_b");
    chk("rev_count", 32'(comm_count), 32'(cnt_exp % (1 << CW)));

    // Hall error
    hall = 3'b111;
    wait_state(3'd3);
    chk("herr_state", 32'(state), 32'd3);
    chk("herr_cause", 32'(fault_cause), 32'd2);
    chk("herr_fault", 32'(fault), 32'd1);
    chk("herr_gates", 32'(gv), 32'd0);
    clear_pulse();
    chk("herr_ign_state", 32'(state), 32'd3);
    chk("herr_ign_cause", 32'(fault_cause), 32'd2);
    hall = 3'b100;
    repeat (4) @(negedge clk);
    clear_pulse();
    chk("herr_clr_state", 32'(state), 32'd0);
    chk("herr_clr_cause", 32'(fault_cause), 32'd0);
    exp_q.push_back(model(3'b100, 1'b0));
    wait_on();
    pop_chk("herr_restart");
    chk("herr_count", 32'(comm_count), 32'(cnt_exp % (1 << CW)));

    // Driver fault pulse
    fault_n = 1'b0;
    repeat (3) @(negedge clk);
    fault_n = 1'b1;
    wait_state(3'd3);
    chk("drv_state", 32'(state), 32'd3);
    chk("drv_cause", 32'(fault_cause), 32'd1);
    chk("drv_gates", 32'(gv), 32'd0);
    repeat (4) @(negedge clk);
    clear_pulse();
    chk("drv_clr_state", 32'(state), 32'd0);
    repeat (3) @(negedge clk);
    chk("wrap_dead", 32'(state), 32'd1);

    // Counter wrap via sector steps during dead time
    for (int i = 0; i < 10; i++) begin
      if (h_valid_step(wrap[i])) cnt_exp++;
      hall = wrap[i];
      repeat (8) @(negedge clk);
      if (i >= 8)
        chk("wrap_count", 32'(comm_count), 32'(cnt_exp % (1 << CW)));
    end
    chk("wrap_zero", 32'(comm_count), 32'd0);
    exp_q.push_back(model(3'b001, 1'b0));
    wait_on();
    pop_chk("wrap_pat");

    // Enable drop
    enable = 1'b0;
    @(negedge clk);
    chk("dis_state", 32'(state), 32'd0);
    chk("dis_gates", 32'(gv), 32'd0);
    chk("dis_count", 32'(comm_count), 32'd0);
    enable = 1'b1;
    exp_q.push_back(model(3'b001, 1'b0));
    wait_on();
    pop_chk("reen_pat");

`ifdef BLDC_STALL_DETECT_EN
    off = 0;
    while (state == 3'd2 && off < 500) begin
      off++;
      @(negedge clk);
    end
    chk("stall_len", 32'(off), 32'd100);
    chk("stall_state", 32'(state), 32'd4);
    chk("stall_fault", 32'(fault), 32'd1);
    chk("stall_cause", 32'(fault_cause), 32'd0);
    chk("stall_gates", 32'(gv), 32'd0);
    clear_pulse();
    chk("stall_clr", 32'(state), 32'd0);
`else
    repeat (300) @(negedge clk);
    chk("nostall_state", 32'(state), 32'd2);
    chk("nostall_pat", 32'(gv), 32'(model(3'b001, 1'b0)));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  function automatic logic h_valid_step(input logic [2:0] h);
    return hsec(h) != 7 && hsec(hall) != 7 && h != hall;
  endfunction

endmodule
